// File: rtl/pdata_seq.sv
// pdata_seq: bit-serial operand loader and shift-add multiply-accumulate engine.
// Operands data_1/data_2 and the accumulator are loaded and read one bit per
// accepted opcode. MUL / MUL_ADD run an unsigned shift-add multiply over SIZE
// cycles and then write the accumulator.
// Optional feature: define PDATA_SEQ_SAT_EN to saturate MUL_ADD overflow to all
// ones. Without it, overflow wraps modulo 2^ACC_W.
module pdata_seq #(
  parameter int SIZE     = 32,
  parameter int ACC_MULT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [2:0] opcode,
  input  logic       op_valid,
  output logic       op_ready,
  output logic       tx,
  output logic       tx_en,
  output logic       busy,
  output logic       done
);

  localparam int ACC_W = ACC_MULT * SIZE;
  localparam int PW    = 2 * SIZE;
  localparam int WW    = (ACC_W > PW) ? ACC_W : PW;
  localparam int CW    = $clog2(SIZE) + 1;

  typedef enum logic [2:0] {
    OP_OUT_DATA1 = 3'd0,
    OP_OUT_DATA2 = 3'd1,
    OP_OUT_RES   = 3'd2,
    OP_LOAD      = 3'd3,
    OP_LOAD_RES  = 3'd4,
    OP_MUL       = 3'd5,
    OP_MUL_ADD   = 3'd6,
    OP_NO_OP     = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SIZE-1:0]   data1_q, data1_d;
  logic [SIZE-1:0]   data2_q, data2_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [SIZE-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              mode_q, mode_d;

  logic [PW-1:0]     prodNext;
  logic [WW-1:0]     prodWide;
  logic [ACC_W-1:0]  prodExt;
  logic [ACC_W-1:0]  accAddResult;

  // Partial product after this cycle's multiplier bit, resized to the accumulator width.
  always_comb begin
    prodNext = prod_q + (mplier_q[0] ? mcand_q : '0);
    prodWide = WW'(prodNext);
    prodExt  = prodWide[ACC_W-1:0];
  end

`ifdef PDATA_SEQ_SAT_EN
  logic [ACC_W:0] accSumWide;

  // Accumulate with an extra carry bit; any carry out clamps the result to all ones.
  always_comb begin
    accSumWide   = {1'b0, acc_q} + {1'b0, prodExt};
    accAddResult = accSumWide[ACC_W] ? {ACC_W{1'b1}} : accSumWide[ACC_W-1:0];
  end
`else
  // Accumulate and let overflow wrap around.
  always_comb begin
    accAddResult = acc_q + prodExt;
  end
`endif

  // Next-state, datapath updates and outputs; everything holds unless an opcode is accepted.
  always_comb begin
    state_d  = state_q;
    data1_d  = data1_q;
    data2_d  = data2_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    op_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    tx       = 1'b0;
    tx_en    = 1'b0;

    case (state_q)
      IDLE: begin
        op_ready = ~rst;
        case (opcode)
          OP_OUT_DATA1: begin tx = data1_q[SIZE-1]; tx_en = ~rst; end
          OP_OUT_DATA2: begin tx = data2_q[SIZE-1]; tx_en = ~rst; end
          OP_OUT_RES:   begin tx = acc_q[ACC_W-1];  tx_en = ~rst; end
          default:      begin tx = 1'b0;            tx_en = 1'b0; end
        endcase
        if (rst) begin
          tx = 1'b0;
        end
        if (op_valid && op_ready) begin
          case (opcode)
            OP_OUT_DATA1: data1_d = {rx, data1_q[SIZE-1:1]};
            OP_OUT_DATA2: data2_d = {rx, data2_q[SIZE-1:1]};
            OP_OUT_RES,
            OP_LOAD_RES:  acc_d = {acc_q[ACC_W-2:0], rx};
            OP_LOAD: begin
              data1_d = {data1_q[SIZE-2:0], rx};
              data2_d = {data2_q[SIZE-2:0], data1_q[SIZE-1]};
            end
            OP_MUL,
            OP_MUL_ADD: begin
              mcand_d  = PW'(data1_q);
              mplier_d = data2_q;
              prod_d   = '0;
              cnt_d    = '0;
              mode_d   = (opcode == OP_MUL_ADD);
              state_d  = MULT;
            end
            default: ;
          endcase
        end
      end

      MULT: begin
        busy     = 1'b1;
        prod_d   = prodNext;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(SIZE - 1)) begin
          acc_d   = mode_q ? accAddResult : prodExt;
          state_d = DONE;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything at once, independent of the clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      data1_q  <= '0;
      data2_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
    end
  end

endmodule

// File: tb/tb_pdata_seq.sv
// tb_pdata_seq: directed plus randomized bench for pdata_seq (SIZE=8, ACC_MULT=4).
// Expected register contents come from an arithmetic model of the opcode rules.
module tb_pdata_seq;

  localparam int SIZE     = 8;
  localparam int ACC_MULT = 4;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [2:0] opcode;
  logic       op_valid;
  logic       op_ready;
  logic       tx;
  logic       tx_en;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int unsigned mD1 = 0;
  int unsigned mD2 = 0;
  int unsigned mAcc = 0;
  logic        lastTx;

  pdata_seq #(.SIZE(SIZE), .ACC_MULT(ACC_MULT)) dut (
    .clk(clk), .rst(rst), .rx(rx), .opcode(opcode), .op_valid(op_valid),
    .op_ready(op_ready), .tx(tx), .tx_en(tx_en), .busy(busy), .done(done)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, "_data1"}, 32'(dut.data1_q), mD1);
    checkOutput({tag, "_data2"}, 32'(dut.data2_q), mD2);
    checkOutput({tag, "_acc"}, dut.acc_q, mAcc);
  endtask

  function automatic void modelMul(input bit addMode);
    longint unsigned p;
    longint unsigned s;
    p = longint'(mD1) * longint'(mD2);
    if (!addMode) begin
      mAcc = int'(p & 64'hFFFF_FFFF);
    end else begin
      s = longint'(mAcc) + p;
`ifdef PDATA_SEQ_SAT_EN
      mAcc = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : int'(s);
`else
      mAcc = int'(s & 64'hFFFF_FFFF);
`endif
    end
  endfunction

  // One opcode cycle in IDLE: checks the serial output, then updates the model if accepted.
  task automatic applyStimulus(input int op, input bit rxBit, input bit valid);
    logic expTx;
    opcode   = 3'(op);
    rx       = rxBit;
    op_valid = valid;
    #1;
    lastTx = tx;
    if (op <= 2) begin
      expTx = (op == 0) ? mD1[7] : (op == 1) ? mD2[7] : mAcc[31];
      checkOutput($sformatf("tx_op%0d", op), {31'b0, tx}, {31'b0, expTx});
      checkOutput($sformatf("txen_op%0d", op), {31'b0, tx_en}, 32'd1);
    end else begin
      checkOutput($sformatf("txen_op%0d", op), {31'b0, tx_en}, 32'd0);
    end
    @(posedge clk);
    #1;
    if (valid) begin
      case (op)
        0: mD1 = (mD1 >> 1) | (int'(rxBit) << 7);
        1: mD2 = (mD2 >> 1) | (int'(rxBit) << 7);
        2, 4: mAcc = (mAcc << 1) | int'(rxBit);
        3: begin
          mD2 = ((mD2 << 1) | (mD1 >> 7)) & 32'hFF;
          mD1 = ((mD1 << 1) | int'(rxBit)) & 32'hFF;
        end
        default: ;
      endcase
    end
    op_valid = 1'b0;
    opcode   = 3'd7;
  endtask

  // Issue MUL (5) or MUL_ADD (6) and follow it through busy and done; optionally hammer LOADs meanwhile.
  task automatic runMul(input int op, input bit stress);
    int cycles;
    applyStimulus(op, 1'b0, 1'b1);
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      if (stress) begin
        opcode   = 3'd3;
        rx       = 1'($urandom);
        op_valid = 1'b1;
        #1;
        checkOutput("ready_in_mult", {31'b0, op_ready}, 32'd0);
      end
      cycles++;
      @(posedge clk);
      #1;
    end
    op_valid = 1'b0;
    opcode   = 3'd7;
    modelMul(op == 6);
    checkOutput("busy_cycles", cycles, SIZE);
    checkOutput("done_pulse", {31'b0, done}, 32'd1);
    checkRegs("after_mul");
    @(posedge clk);
    #1;
    checkOutput("done_cleared", {31'b0, done}, 32'd0);
    checkOutput("ready_after", {31'b0, op_ready}, 32'd1);
  endtask

  initial begin
    int sawDone;
    logic [31:0] word;
    logic [31:0] expWord;
    logic [7:0] pattern;

    rst      = 1'b1;
    rx       = 1'b0;
    opcode   = 3'd0;
    op_valid = 1'b0;
    #12;
    checkOutput("rst_ready", {31'b0, op_ready}, 32'd0);
    checkOutput("rst_txen", {31'b0, tx_en}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkRegs("rst");
    @(posedge clk);
    #1;
    rst    = 1'b0;
    opcode = 3'd7;
    #1;
    checkOutput("ready_post_rst", {31'b0, op_ready}, 32'd1);

    // Load 0x03 then 0x05 MSB-first and multiply
    for (int i = 0; i < 16; i++) begin
      pattern = (i < 8) ? 8'h03 : 8'h05;
      applyStimulus(3, pattern[7 - (i % 8)], 1'b1);
    end
    checkOutput("load_d1", 32'(dut.data1_q), 32'h05);
    checkOutput("load_d2", 32'(dut.data2_q), 32'h03);
    runMul(5, 1'b0);
    checkOutput("mul_const", dut.acc_q, 32'h0000000F);
    runMul(6, 1'b0);
    checkOutput("muladd_const", dut.acc_q, 32'h0000001E);

    // Stream the accumulator out MSB-first
    word    = '0;
    expWord = mAcc;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(2, 1'($urandom), 1'b1);
      word = {word[30:0], lastTx};
    end
    checkOutput("outres_stream", word, expWord);
    checkRegs("after_stream");

    // Overflow case: acc 0xFFFFFFF0 plus 0xFF*0xFF
    for (int i = 31; i >= 0; i--) begin
      expWord = 32'hFFFF_FFF0;
      applyStimulus(4, expWord[i], 1'b1);
    end
    for (int i = 0; i < 16; i++) applyStimulus(3, 1'b1, 1'b1);
    runMul(6, 1'b0);
`ifdef PDATA_SEQ_SAT_EN
    checkOutput("ovf_const", dut.acc_q, 32'hFFFF_FFFF);
`else
    checkOutput("ovf_const", dut.acc_q, 32'h0000_FDF1);
`endif

    // LOADs offered during MULT must be ignored
    for (int i = 0; i < 16; i++) applyStimulus(3, 1'($urandom), 1'b1);
    runMul(5, 1'b1);

    // Randomized opcode mix
    for (int n = 0; n < 60; n++) begin
      int op;
      bit valid;
      op    = int'($urandom_range(0, 7));
      valid = ($urandom_range(0, 3) != 0);
      if ((op == 5 || op == 6) && valid) runMul(op, 1'($urandom));
      else applyStimulus(op, 1'($urandom), valid);
      checkRegs($sformatf("rand%0d", n));
    end

    // Reset in the middle of a multiply
    for (int i = 0; i < 16; i++) applyStimulus(3, 1'($urandom), 1'b1);
    applyStimulus(5, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    opcode = 3'd0;
    rst    = 1'b1;
    mD1 = 0; mD2 = 0; mAcc = 0;
    #1;
    checkRegs("mid_rst");
    checkOutput("mid_rst_ready", {31'b0, op_ready}, 32'd0);
    checkOutput("mid_rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("mid_rst_done", {31'b0, done}, 32'd0);
    checkOutput("mid_rst_txen", {31'b0, tx_en}, 32'd0);
    @(posedge clk);
    #2;
    rst    = 1'b0;
    opcode = 3'd7;
    #1;
    checkOutput("ready_after_abort", {31'b0, op_ready}, 32'd1);
    sawDone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) sawDone++;
    end
    checkOutput("no_done_after_abort", sawDone, 0);
    checkRegs("post_abort");

    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/pdata_seq.md
PDATA_SEQ -- requirements
Module: pdata_seq

Interface
REQ-001 The block SHALL have parameter SIZE, default 32, giving the width of the data_1 and data_2 operand registers (minimum 2).
REQ-002 The block SHALL have parameter ACC_MULT, default 4, making the accumulator ACC_W = ACC_MULT*SIZE bits wide (minimum 2).
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port rx, input, 1 bit: serial data-in bit for shift opcodes.
REQ-006 Port opcode, input, 3 bits: 0 OUT_DATA1, 1 OUT_DATA2, 2 OUT_RES, 3 LOAD, 4 LOAD_RES, 5 MUL, 6 MUL_ADD, 7 NO_OP.
REQ-007 Port op_valid, input, 1 bit: opcode and rx are valid this cycle.
REQ-008 Port op_ready, output, 1 bit: the block accepts an opcode this cycle.
REQ-009 Port tx, output, 1 bit: serial data-out bit.
REQ-010 Port tx_en, output, 1 bit: tx carries meaningful data.
REQ-011 Port busy, output, 1 bit: a multiply is in progress.
REQ-012 Port done, output, 1 bit: one-cycle pulse on multiply completion.

Function
REQ-013 An opcode SHALL be accepted only on a rising edge where op_valid=1 and op_ready=1; otherwise all registers hold.
REQ-014 The FSM SHALL have states IDLE, MULT and DONE; op_ready=1 only in IDLE, busy=1 only in MULT, done=1 only in DONE.
REQ-015 Accepted OUT_DATA1 SHALL set data_1 <= {rx, data_1[SIZE-1:1]}; accepted OUT_DATA2 SHALL do the same on data_2.
REQ-016 Accepted OUT_RES and LOAD_RES SHALL set acc <= {acc[ACC_W-2:0], rx}.
REQ-017 Accepted LOAD SHALL set data_1 <= {data_1[SIZE-2:0], rx} and data_2 <= {data_2[SIZE-2:0], data_1[SIZE-1]} in the same edge.
REQ-018 In IDLE, tx SHALL be data_1[SIZE-1], data_2[SIZE-1] or acc[ACC_W-1] for opcode 0, 1 or 2 respectively, with tx_en=1; otherwise tx=0 and tx_en=0 (no tri-state).
REQ-019 Accepted MUL or MUL_ADD SHALL snapshot data_1 and data_2, clear a 2*SIZE-bit product register and a bit counter, latch the mode, and enter MULT.
REQ-020 MULT SHALL perform unsigned shift-add multiplication, one multiplier bit per cycle, for exactly SIZE cycles.
REQ-021 On the edge ending the SIZE-th MULT cycle, acc SHALL be written and the FSM SHALL enter DONE: MUL gives acc <= zero-extended product; MUL_ADD gives acc <= acc + zero-extended product.
REQ-022 If ACC_W < 2*SIZE, the product SHALL be truncated to its low ACC_W bits.
REQ-023 DONE SHALL last exactly one cycle, then return to IDLE; from MUL acceptance at edge k, done is high during the cycle after edge k+SIZE.
REQ-024 Without the saturation option, MUL_ADD overflow SHALL wrap modulo 2^ACC_W.
REQ-025 data_1 and data_2 SHALL be unchanged by MUL and MUL_ADD.
REQ-026 NO_OP, and any opcode presented while op_ready=0, SHALL have no effect.

Reset
REQ-027 Asserting rst SHALL immediately clear data_1, data_2, acc, the product register and the counter, and force IDLE, regardless of clock.
REQ-028 Asserting rst mid-MULT SHALL abort the multiply; acc reads 0 and no done pulse is produced.
REQ-029 While rst is high: op_ready=0, busy=0, done=0, tx=0, tx_en=0; op_ready=1 from the first cycle after deassertion.

Configuration
REQ-030 With macro PDATA_SEQ_SAT_EN defined, a MUL_ADD whose unsigned sum exceeds 2^ACC_W-1 SHALL load acc with all ones; MUL truncation per REQ-022 is unaffected.
REQ-031 Without PDATA_SEQ_SAT_EN, no saturation logic SHALL be present and REQ-024 applies.

Verification (SIZE=8, ACC_MULT=4)
REQ-032 16 LOAD cycles, rx = 0x03 then 0x05 MSB-first, then MUL -> busy for 8 cycles, done one cycle later, acc=0x0000000F, data_1=0x05, data_2=0x03.
REQ-033 Following MUL_ADD with the same operands -> acc=0x0000001E; then 32 OUT_RES cycles -> tx emits 0x0000001E MSB-first with tx_en=1.
REQ-034 LOAD_RES acc=0xFFFFFFF0, data 0xFF*0xFF, MUL_ADD -> acc=0x0000FDF1 without the macro, 0xFFFFFFFF with PDATA_SEQ_SAT_EN.
REQ-035 LOAD opcodes with op_valid=1 during MULT -> op_ready=0, data_1/data_2 unchanged, product still correct.
REQ-036 rst pulsed at MULT cycle 4 -> all registers 0, no done, IDLE with op_ready=1 the cycle after release.
